// File: rtl/rect_layer_render.sv
// rect_layer_render: double-buffered multi-rectangle pixel renderer, 2-cycle latency; RECT_BORDER_EN inverts each rectangle's outer ring
module rect_layer_render #(
    parameter int          CORDW     = 16,
    parameter int          NUM_RECTS = 4,
    parameter int          IDXW      = 2,
    parameter int          H_OFFS    = 0,
    parameter int          V_OFFS    = 0,
    parameter logic [11:0] BG_COLOR  = 12'h142
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    input  logic                 frame_start,
    input  logic                 de,
    input  logic [CORDW-1:0]     sx,
    input  logic [CORDW-1:0]     sy,
    input  logic                 is_prog_mode,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  logic [4*CORDW+12:0]  wr_data,
    input  logic                 commit,
    output logic [3:0]           dispcolor_r,
    output logic [3:0]           dispcolor_g,
    output logic [3:0]           dispcolor_b,
    output logic                 de_out
);
    localparam int DW = 4*CORDW+13;
    localparam logic [CORDW:0] HO  = H_OFFS[CORDW:0];
    localparam logic [CORDW:0] VO  = V_OFFS[CORDW:0];
    localparam logic [CORDW:0] ONE = 1;

    logic [DW-1:0]  shadow_q [NUM_RECTS];
    logic [DW-1:0]  shadow_d [NUM_RECTS];
    logic [DW-1:0]  active_q [NUM_RECTS];
    logic [DW-1:0]  active_d [NUM_RECTS];
    logic           commit_pending_q, commit_pending_d;
    logic           swap;
    logic [11:0]    col1_q, col1_d;
    logic           de1_q, prog1_q;
    logic [11:0]    color_q, color_d;
    logic           de_out_q;
    logic           hit_s [NUM_RECTS];
    logic [11:0]    col_s [NUM_RECTS];
    logic [CORDW:0] sxe, sye;

    assign sxe  = {1'b0, sx};
    assign sye  = {1'b0, sy};
    assign swap = frame_start && (commit_pending_q || commit);

    // Per-slot hit test against the active table; edges are widened by one bit so they clip instead of wrapping
    for (genvar i = 0; i < NUM_RECTS; i++) begin : g_slot
        logic [DW-1:0]  e;
        logic [CORDW:0] xl, xr, yl, yr;
        assign e  = active_q[i];
        assign xl = {1'b0, e[4*CORDW-1 -: CORDW]} + HO;
        assign xr = {1'b0, e[4*CORDW-1 -: CORDW]} + {1'b0, e[2*CORDW-1 -: CORDW]} + HO;
        assign yl = {1'b0, e[3*CORDW-1 -: CORDW]} + VO;
        assign yr = {1'b0, e[3*CORDW-1 -: CORDW]} + {1'b0, e[CORDW-1:0]} + VO;
        assign hit_s[i] = e[DW-1] && sxe >= xl && sxe < xr && sye >= yl && sye < yr;
`ifdef RECT_BORDER_EN
        logic border;
        assign border   = sxe == xl || sxe == xr - ONE || sye == yl || sye == yr - ONE;
        assign col_s[i] = border ? ~e[DW-2 -: 12] : e[DW-2 -: 12];
`else
        assign col_s[i] = e[DW-2 -: 12];
`endif
    end

    // Table writes, deferred commit and frame-aligned shadow-to-active copy (copy sees pre-write shadow)
    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
            shadow_d[i] = (wr_en && wr_idx == IDXW'(i)) ? wr_data : shadow_q[i];
            active_d[i] = swap ? shadow_q[i] : active_q[i];
        end
        commit_pending_d = swap ? 1'b0 : (commit_pending_q || commit);
    end

    // S1 priority select: scanning downward lets the lowest-index hit win
    always_comb begin
        col1_d = BG_COLOR;
        for (int i = NUM_RECTS-1; i >= 0; i--)
            col1_d = hit_s[i] ? col_s[i] : col1_d;
    end

    // S2 blanking: black outside de or when not in program mode
    always_comb color_d = (de1_q && prog1_q) ? col1_q : 12'h000;

    // State and pipeline registers
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            commit_pending_q <= 1'b0;
            col1_q           <= '0;
            de1_q            <= 1'b0;
            prog1_q          <= 1'b0;
            color_q          <= '0;
            de_out_q         <= 1'b0;
        end else begin
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            col1_q           <= col1_d;
            de1_q            <= de;
            prog1_q          <= is_prog_mode;
            color_q          <= color_d;
            de_out_q         <= de1_q;
        end
    end

    assign dispcolor_r = color_q[11:8];
    assign dispcolor_g = color_q[7:4];
    assign dispcolor_b = color_q[3:0];
    assign de_out      = de_out_q;
endmodule
